// File: rtl/shift_pkg.sv
// Shared opcode encodings and FSM state type for the sequential shift unit.
// Pure definitions, no logic; no latency or backpressure of its own.
package shift_pkg;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASL = 3'b010;
    localparam logic [2:0] OP_ASR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 110 and 111 are the only encodings above ROR and both are illegal.
    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit-position shift/rotate step; purely combinational, zero latency.
// Illegal opcodes pass the value through with out_bit=0.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (opcode)
            OP_LSL, OP_ASL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                out_bit    = value[WIDTH-1];
            end
            OP_LSR: begin
                next_value = {1'b0, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            OP_ASR: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            OP_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
            OP_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Sequential shifter: one bit per cycle, done pulses amount cycles after acceptance (next cycle if amount=0).
// start is only sampled in IDLE; requests during SHIFT/DONE are dropped, not queued.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       opcode,
    input  logic [AW-1:0]    amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [2:0]       op_q;
    logic [AW-1:0]    cnt_q;
    logic             ovf_acc_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] dout_q;
    logic             carry_q;
    logic             ovf_q;
    logic             err_q;

    logic [WIDTH-1:0] step_val;
    logic             step_bit;
    logic             ovf_d;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value      (work_q),
        .opcode     (op_q),
        .next_value (step_val),
        .out_bit    (step_bit)
    );

    // Sticky: any ASL step that flips the sign bit marks the whole operation.
    assign ovf_d = ovf_acc_q
                 | ((op_q == OP_ASL) && (step_val[WIDTH-1] != work_q[WIDTH-1]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        work_q    <= data_in;
                        op_q      <= opcode;
                        cnt_q     <= amount;
                        ovf_acc_q <= 1'b0;
                        if (amount != '0) begin
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            dout_q  <= data_in;
                            carry_q <= 1'b0;
                            ovf_q   <= 1'b0;
                            err_q   <= !op_legal(opcode);
                        end
                    end
                end
                ST_SHIFT: begin
                    work_q    <= step_val;
                    cnt_q     <= cnt_q - 1'b1;
                    ovf_acc_q <= ovf_d;
                    if (cnt_q == AW'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        dout_q  <= step_val;
                        carry_q <= step_bit;
                        ovf_q   <= ovf_d;
                        err_q   <= !op_legal(op_q);
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = dout_q;
    assign carry    = carry_q;
    assign ovf      = ovf_q;
    assign err      = err_q;

endmodule

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width; power of two, minimum 4.
REQ-002 SHALL have derived localparam AW = $clog2(WIDTH): shift-amount width.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1: request; sampled only in IDLE.
REQ-006 SHALL have port data_in, input, WIDTH: operand, captured on the accepting edge.
REQ-007 SHALL have port opcode, input, 3: operation, captured on the accepting edge.
REQ-008 SHALL have port amount, input, AW: number of single-bit steps, captured on the accepting edge.
REQ-009 SHALL have port busy, output, 1: high in SHIFT.
REQ-010 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port data_out, output, WIDTH: registered result.
REQ-012 SHALL have port carry, output, 1: last bit shifted or rotated out.
REQ-013 SHALL have port ovf, output, 1: sign change during an arithmetic left shift.
REQ-014 SHALL have port err, output, 1: illegal opcode flag, valid with done.

Function
REQ-015 SHALL use opcodes 000 LSL, 001 LSR, 010 ASL, 011 ASR, 100 ROL, 101 ROR; 110 and 111 are illegal.
REQ-016 SHALL perform one bit position per step:
- LSL and ASL fill with 0.
- LSR fills MSB with 0.
- ASR replicates MSB.
- ROL and ROR wrap the exiting bit.
REQ-017 SHALL implement FSM states IDLE, SHIFT and DONE; reset state is IDLE.
REQ-018 SHALL, in IDLE with start=1, load the working register, opcode and counter=amount; next state is SHIFT if amount>0, else DONE.
REQ-019 SHALL, in SHIFT, perform one step and decrement the counter each cycle, moving to DONE on the edge where the counter goes 1->0.
REQ-020 SHALL, given acceptance at edge k, present done=1 in the cycle after edge k+amount; amount=0 gives done in the cycle after edge k.
REQ-021 SHALL, in DONE:
- assert done for exactly one cycle;
- return to IDLE unconditionally;
- ignore start in that cycle.
REQ-022 SHALL update data_out, carry, ovf and err only on the edge entering DONE, holding them until the next completion or reset.
REQ-023 SHALL ignore start while busy=1 or done=1; a held start is accepted again in the IDLE cycle after DONE.
REQ-024 SHALL set carry=0 when amount=0.
REQ-025 SHALL set ovf=1 if any ASL step changes the MSB, and ovf=0 for all other opcodes.
REQ-026 SHALL, for an illegal opcode, give data_out=data_in, carry=0, ovf=0 and err=1, with the same latency as a legal opcode.
REQ-027 SHALL keep busy and done mutually exclusive.

Reset
REQ-028 SHALL, with rst_n=0 at an edge, enter IDLE and clear busy, done, data_out, carry, ovf, err and the counter to 0, including mid-SHIFT.
REQ-029 SHALL produce no done pulse for an operation aborted by reset.

Structure
REQ-030 SHALL place the opcode constants and the FSM state type in shared package shift_pkg.
REQ-031 SHALL instantiate one combinational sub-module shift_step (WIDTH): inputs value and opcode; outputs next value and out_bit.

Verification (WIDTH=8)
REQ-032 SHALL check: data_in=10000000, LSR, amount=3 -> done after 3 cycles, data_out=00010000, carry=0.
REQ-033 SHALL check: data_in=10010001, ASR, amount=2 -> data_out=11100100, carry=0; ROL, amount=1 -> data_out=00100011, carry=1.
REQ-034 SHALL check: data_in=01000000, ASL, amount=1 -> data_out=10000000, ovf=1; same with LSL -> ovf=0.
REQ-035 SHALL check: amount=0, ROR -> done in the cycle after acceptance, data_out=data_in, carry=0; opcode=110 -> err=1, data_out=data_in.
REQ-036 SHALL check: start pulsed with new data mid-SHIFT -> ignored, original result unchanged; start held high -> back-to-back operations with one IDLE cycle between.
REQ-037 SHALL check: rst_n=0 for one edge during SHIFT with amount=7 -> IDLE, all outputs 0, no done pulse.
